// File: rtl/scu_dsp_dma_bridge_pkg.sv
// Shared types, command-field positions and address-step helper for the SCU DSP DMA bridge.
package scu_dsp_dma_bridge_pkg;

  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned TO_W    = 8;

  localparam int unsigned CMD_DIR_BIT = 12;
  localparam int unsigned CMD_ADD_HI  = 17;
  localparam int unsigned CMD_ADD_LO  = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_BUS = 3'd1,
    ST_RD_ACK = 3'd2,
    ST_WR_ACK = 3'd3,
    ST_WR_BUS = 3'd4,
    ST_DONE   = 3'd5
  } DspDmaState_t;

  // ADD=0 keeps the address fixed; otherwise the step is 2^(ADD-1) words.
  function automatic logic [ADDR_W-1:0] AddStep(input logic [2:0] add);
    AddStep = (add == 3'd0) ? '0 : (ADDR_W'(1) << (add - 3'd1));
  endfunction

endpackage

// File: rtl/scu_dsp_dma_bridge.sv
// Bus-side DMA engine: turns DSP word requests into single-word SCU bus transfers
// between DSP data RAM and external memory, with bus timeout and sticky error flag.
module scu_dsp_dma_bridge
  import scu_dsp_dma_bridge_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic [DATA_W-1:0] i_dso,
  input  logic              i_ra0w,
  input  logic              i_wa0w,
  input  logic              i_dmaw,
  input  logic              i_dmaReq,
  output logic              o_dmaAck,
  output logic [DATA_W-1:0] o_dmaDi,
  input  logic [DATA_W-1:0] i_dmaDo,
  input  logic              i_dmaWe,
  input  logic              i_dmaRun,
  input  logic              i_dmaLast,
  output logic              o_dmaEnd,
  output logic [ADDR_W-1:0] o_busA,
  output logic [DATA_W-1:0] o_busDo,
  input  logic [DATA_W-1:0] i_busDi,
  output logic              o_busWe,
  output logic              o_busReq,
  input  logic              i_busAck,
  output logic              o_busy,
  output logic              o_err
);

  DspDmaState_t r_state, w_nextState;

  logic [ADDR_W-1:0] r_ra0, r_wa0;
  logic              r_dir;
  logic [2:0]        r_add;
  logic              r_pend, r_lastL, r_armed, r_err, r_weBad, r_runD, r_abort;
  logic [DATA_W-1:0] r_din;
  logic [TO_W-1:0]   r_tocnt;

  logic              w_busy, w_runFall, w_abort, w_inBus, w_timeout;
  logic              w_setErr, w_toIdleAbort, w_clrPend;
  logic [ADDR_W-1:0] w_rdStep, w_wrStep;
  logic              w_unusedDso;

  assign w_busy        = (r_state != ST_IDLE) || r_pend;
  assign w_runFall     = r_runD && !i_dmaRun;
  assign w_abort       = r_abort || (w_runFall && w_busy);
  assign w_inBus       = (r_state == ST_RD_BUS) || (r_state == ST_WR_BUS);
  assign w_timeout     = w_inBus && !i_busAck && (r_tocnt == TO_W'(TIMEOUT - 1));
  assign w_rdStep      = (r_add != 3'd0) ? ADDR_W'(1) : '0;
  assign w_wrStep      = AddStep(r_add);
  assign w_setErr      = ((r_state == ST_IDLE) && r_pend && !w_abort && r_weBad) || w_timeout;
  assign w_toIdleAbort = w_abort && (w_nextState == ST_IDLE);
  assign w_clrPend     = (r_state == ST_RD_ACK) || (r_state == ST_WR_ACK) ||
                         (r_state == ST_DONE) || w_toIdleAbort;
  assign w_unusedDso   = ^i_dso[DATA_W-1:ADDR_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (i_ce) begin
      r_state <= w_nextState;
    end
  end

  // A DMA_RUN drop lets the current bus access finish, then returns to IDLE without DMA_END.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pend && !w_abort) begin
          if (r_weBad)    w_nextState = ST_DONE;
          else if (r_dir) w_nextState = ST_WR_ACK;
          else            w_nextState = ST_RD_BUS;
        end
      end
      ST_RD_BUS: begin
        if (i_busAck)       w_nextState = w_abort ? ST_IDLE : ST_RD_ACK;
        else if (w_timeout) w_nextState = w_abort ? ST_IDLE : ST_DONE;
      end
      ST_RD_ACK: w_nextState = (r_lastL && !w_abort) ? ST_DONE : ST_IDLE;
      ST_WR_ACK: w_nextState = ST_WR_BUS;
      ST_WR_BUS: begin
        if (i_busAck)       w_nextState = (r_lastL && !w_abort) ? ST_DONE : ST_IDLE;
        else if (w_timeout) w_nextState = w_abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busReq = 1'b0;
    o_busWe  = 1'b0;
    o_busA   = '0;
    o_busDo  = '0;
    o_dmaAck = 1'b0;
    o_dmaEnd = 1'b0;
    case (r_state)
      ST_RD_BUS: begin
        o_busReq = 1'b1;
        o_busA   = r_ra0;
      end
      ST_RD_ACK: o_dmaAck = 1'b1;
      ST_WR_ACK: o_dmaAck = 1'b1;
      ST_WR_BUS: begin
        o_busReq = 1'b1;
        o_busWe  = 1'b1;
        o_busA   = r_wa0;
        o_busDo  = r_din;
      end
      ST_DONE:   o_dmaEnd = 1'b1;
      default:   o_busReq = 1'b0;
    endcase
  end

  assign o_dmaDi = r_din;
  assign o_busy  = w_busy;
  assign o_err   = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ra0   <= '0;
      r_wa0   <= '0;
      r_dir   <= 1'b0;
      r_add   <= '0;
      r_pend  <= 1'b0;
      r_lastL <= 1'b0;
      r_armed <= 1'b0;
      r_err   <= 1'b0;
      r_weBad <= 1'b0;
      r_runD  <= 1'b0;
      r_abort <= 1'b0;
      r_din   <= '0;
      r_tocnt <= '0;
    end else if (i_ce) begin
      r_runD <= i_dmaRun;

      if (i_ra0w && !w_busy)
        r_ra0 <= i_dso[ADDR_W-1:0];
      else if ((r_state == ST_RD_BUS) && i_busAck)
        r_ra0 <= r_ra0 + w_rdStep;

      if (i_wa0w && !w_busy)
        r_wa0 <= i_dso[ADDR_W-1:0];
      else if ((r_state == ST_WR_BUS) && i_busAck)
        r_wa0 <= r_wa0 + w_wrStep;

      if (i_dmaw) begin
        r_dir <= i_dso[CMD_DIR_BIT];
        r_add <= i_dso[CMD_ADD_HI:CMD_ADD_LO];
      end

      if (i_dmaw)
        r_armed <= 1'b1;
      else if ((r_state == ST_DONE) || w_toIdleAbort)
        r_armed <= 1'b0;

      if (w_setErr)
        r_err <= 1'b1;
      else if (i_dmaw)
        r_err <= 1'b0;

      // Direction mismatch is judged against the DMA_WE presented with the request.
      if (w_clrPend) begin
        r_pend <= 1'b0;
      end else if (i_dmaReq && r_armed && !r_pend) begin
        r_pend  <= 1'b1;
        r_weBad <= (i_dmaWe != r_dir);
      end

      if ((r_state == ST_IDLE) && r_pend)
        r_lastL <= i_dmaLast;

      if ((r_state == ST_RD_BUS) && i_busAck)
        r_din <= i_busDi;
      else if (r_state == ST_WR_ACK)
        r_din <= i_dmaDo;

      if (!w_inBus || i_busAck)
        r_tocnt <= '0;
      else
        r_tocnt <= r_tocnt + TO_W'(1);

      if (w_toIdleAbort)
        r_abort <= 1'b0;
      else if (w_runFall && w_busy)
        r_abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scu_dsp_dma_bridge.sv
// Randomized self-checking bench for scu_dsp_dma_bridge against a transaction-level
// model of the address registers, step rules and word/pulse timing.
module tb_scu_dsp_dma_bridge;
  import scu_dsp_dma_bridge_pkg::*;

  logic        i_clk, i_rst_n, i_ce;
  logic [31:0] i_dso;
  logic        i_ra0w, i_wa0w, i_dmaw, i_dmaReq;
  logic        o_dmaAck;
  logic [31:0] o_dmaDi, i_dmaDo;
  logic        i_dmaWe, i_dmaRun, i_dmaLast, o_dmaEnd;
  logic [24:0] o_busA;
  logic [31:0] o_busDo, i_busDi;
  logic        o_busWe, o_busReq, i_busAck, o_busy, o_err;

  int assertCount = 0;
  int failCount   = 0;
  int ackClks     = 0;
  int endClks     = 0;
  bit ceMode      = 1'b0;

  logic [24:0] mRa0, mWa0;
  logic        mDir;
  logic [2:0]  mAdd;

  scu_dsp_dma_bridge dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_dso(i_dso),
    .i_ra0w(i_ra0w), .i_wa0w(i_wa0w), .i_dmaw(i_dmaw), .i_dmaReq(i_dmaReq),
    .o_dmaAck(o_dmaAck), .o_dmaDi(o_dmaDi), .i_dmaDo(i_dmaDo), .i_dmaWe(i_dmaWe),
    .i_dmaRun(i_dmaRun), .i_dmaLast(i_dmaLast), .o_dmaEnd(o_dmaEnd),
    .o_busA(o_busA), .o_busDo(o_busDo), .i_busDi(i_busDi), .o_busWe(o_busWe),
    .o_busReq(o_busReq), .i_busAck(i_busAck), .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse widths are measured in raw clocks so CE gating shows up as doubled widths.
  always @(negedge i_clk) begin
    if (o_dmaAck) ackClks++;
    if (o_dmaEnd) endClks++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one CE-enabled cycle; in ceMode a CE=0 clock follows it.
  task automatic applyStimulus();
    i_ce = 1'b1;
    @(posedge i_clk); #1;
    if (ceMode) begin
      i_ce = 1'b0;
      @(posedge i_clk); #1;
      i_ce = 1'b1;
    end
  endtask

  function automatic logic [24:0] wrStepOf(input logic [2:0] add);
    int s;
    if (add == 3'd0) return 25'd0;
    s = 1;
    for (int i = 1; i < int'(add); i++) s = s * 2;
    return 25'(s);
  endfunction

  function automatic logic [24:0] rdStepOf(input logic [2:0] add);
    return (add == 3'd0) ? 25'd0 : 25'd1;
  endfunction

  task automatic loadRa0(input logic [24:0] addr);
    i_dso = {7'd0, addr}; i_ra0w = 1'b1;
    applyStimulus();
    i_ra0w = 1'b0;
    mRa0 = addr;
  endtask

  task automatic loadWa0(input logic [24:0] addr);
    i_dso = {7'd0, addr}; i_wa0w = 1'b1;
    applyStimulus();
    i_wa0w = 1'b0;
    mWa0 = addr;
  endtask

  task automatic dmaCmd(input logic dir, input logic [2:0] add);
    i_dso = (32'(add) << 15) | (32'(dir) << 12); i_dmaw = 1'b1;
    applyStimulus();
    i_dmaw = 1'b0;
    mDir = dir; mAdd = add;
  endtask

  task automatic doReadWord(input logic [31:0] data, input bit isLast, input int delay, input bit dupReq);
    i_dmaReq = 1'b1; i_dmaWe = 1'b0; i_dmaLast = isLast;
    applyStimulus();
    i_dmaReq = 1'b0;
    if (dupReq) begin
      i_dmaReq = 1'b1; i_ra0w = 1'b1; i_dso = 32'h0155_5555;
    end
    checkOutput("rdReqEarly", o_busReq, 0);
    checkOutput("rdBusyPend", o_busy, 1);
    applyStimulus();
    i_dmaReq = 1'b0; i_ra0w = 1'b0;
    for (int d = 0; d <= delay; d++) begin
      checkOutput("rdBusReq", o_busReq, 1);
      checkOutput("rdBusA", o_busA, mRa0);
      checkOutput("rdBusWe", o_busWe, 0);
      if (d == delay) begin
        i_busAck = 1'b1; i_busDi = data;
      end
      applyStimulus();
    end
    i_busAck = 1'b0; i_busDi = $urandom;
    checkOutput("rdDmaAck", o_dmaAck, 1);
    checkOutput("rdDmaDi", o_dmaDi, data);
    checkOutput("rdReqDrop", o_busReq, 0);
    checkOutput("rdEndEarly", o_dmaEnd, 0);
    mRa0 = mRa0 + rdStepOf(mAdd);
    applyStimulus();
    checkOutput("rdDiHold", o_dmaDi, data);
    if (isLast) begin
      checkOutput("rdEnd", o_dmaEnd, 1);
      applyStimulus();
    end else begin
      checkOutput("rdNoEnd", o_dmaEnd, 0);
    end
    checkOutput("rdIdle", o_busy, 0);
    i_dmaLast = 1'b0;
  endtask

  task automatic doWriteWord(input logic [31:0] data, input bit isLast, input int delay);
    i_dmaReq = 1'b1; i_dmaWe = 1'b1; i_dmaDo = data; i_dmaLast = isLast;
    applyStimulus();
    i_dmaReq = 1'b0;
    checkOutput("wrAckEarly", o_dmaAck, 0);
    applyStimulus();
    checkOutput("wrDmaAck", o_dmaAck, 1);
    checkOutput("wrBusEarly", o_busReq, 0);
    applyStimulus();
    i_dmaDo = $urandom;
    for (int d = 0; d <= delay; d++) begin
      checkOutput("wrBusReq", o_busReq, 1);
      checkOutput("wrBusWe", o_busWe, 1);
      checkOutput("wrBusA", o_busA, mWa0);
      checkOutput("wrBusDo", o_busDo, data);
      if (d == delay) i_busAck = 1'b1;
      applyStimulus();
    end
    i_busAck = 1'b0;
    mWa0 = mWa0 + wrStepOf(mAdd);
    checkOutput("wrReqDrop", o_busReq, 0);
    checkOutput("wrEnd", o_dmaEnd, isLast);
    if (isLast) applyStimulus();
    checkOutput("wrIdle", o_busy, 0);
    i_dmaLast = 1'b0;
  endtask

  initial begin
    int ackBase, endBase, cnt, words, delay;
    logic [31:0] data;
    logic        dir;
    logic [2:0]  add;

    i_rst_n = 1'b0; i_ce = 1'b1; i_dso = '0; i_ra0w = 1'b0; i_wa0w = 1'b0; i_dmaw = 1'b0;
    i_dmaReq = 1'b0; i_dmaDo = '0; i_dmaWe = 1'b0; i_dmaRun = 1'b1; i_dmaLast = 1'b0;
    i_busDi = '0; i_busAck = 1'b0;
    mRa0 = '0; mWa0 = '0; mDir = 1'b0; mAdd = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rstBusReq", o_busReq, 0);
    checkOutput("rstDmaAck", o_dmaAck, 0);
    checkOutput("rstDmaEnd", o_dmaEnd, 0);
    checkOutput("rstBusy", o_busy, 0);
    checkOutput("rstErr", o_err, 0);
    checkOutput("rstDmaDi", o_dmaDi, 0);
    i_rst_n = 1'b1;
    applyStimulus();

    $display("[TB] three-word read from 0x100");
    loadRa0(25'h100);
    dmaCmd(1'b0, 3'd1);
    ackBase = ackClks; endBase = endClks;
    doReadWord(32'hA, 1'b0, 1, 1'b0);
    doReadWord(32'hB, 1'b0, 0, 1'b0);
    doReadWord(32'hC, 1'b1, 2, 1'b0);
    checkOutput("rd3AckCount", ackClks - ackBase, 3);
    checkOutput("rd3EndCount", endClks - endBase, 1);
    dmaCmd(1'b0, 3'd1);
    checkOutput("rd3FinalRa0", mRa0, 25'h103);
    doReadWord($urandom, 1'b1, 0, 1'b0);

    $display("[TB] two-word write with address wrap");
    loadWa0(25'h1FF_FFFF);
    dmaCmd(1'b1, 3'd3);
    ackBase = ackClks; endBase = endClks;
    doWriteWord(32'h11, 1'b0, 0);
    doWriteWord(32'h22, 1'b1, 1);
    checkOutput("wr2AckCount", ackClks - ackBase, 2);
    checkOutput("wr2EndCount", endClks - endBase, 1);

    $display("[TB] bus timeout");
    loadRa0(25'(($urandom)));
    dmaCmd(1'b0, 3'd2);
    i_dmaReq = 1'b1; i_dmaWe = 1'b0; i_dmaLast = 1'b1;
    applyStimulus();
    i_dmaReq = 1'b0;
    applyStimulus();
    cnt = 0;
    while (o_busReq && cnt < 300) begin
      cnt++;
      applyStimulus();
    end
    checkOutput("toReqCycles", cnt, 255);
    checkOutput("toReqDrop", o_busReq, 0);
    checkOutput("toEnd", o_dmaEnd, 1);
    checkOutput("toErr", o_err, 1);
    i_dmaLast = 1'b0;
    applyStimulus();
    checkOutput("toErrSticky", o_err, 1);
    checkOutput("toIdle", o_busy, 0);
    dmaCmd(1'b0, 3'd2);
    checkOutput("toErrClear", o_err, 0);
    doReadWord($urandom, 1'b1, 1, 1'b0);

    $display("[TB] dropped request and RA0W while busy");
    loadRa0(25'h0_0040);
    dmaCmd(1'b0, 3'd4);
    doReadWord(32'h5A5A_0001, 1'b0, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("dupNoAccess", o_busReq, 0);
      applyStimulus();
    end
    doReadWord(32'h5A5A_0002, 1'b1, 0, 1'b0);

    $display("[TB] direction mismatch");
    dmaCmd(1'b0, 3'd1);
    i_dmaReq = 1'b1; i_dmaWe = 1'b1; i_dmaLast = 1'b0;
    applyStimulus();
    i_dmaReq = 1'b0;
    applyStimulus();
    checkOutput("weEnd", o_dmaEnd, 1);
    checkOutput("weErr", o_err, 1);
    checkOutput("weNoBus", o_busReq, 0);
    applyStimulus();
    i_dmaReq = 1'b1; i_dmaWe = 1'b0;
    applyStimulus();
    i_dmaReq = 1'b0;
    checkOutput("unarmedReq", o_busy, 0);

    $display("[TB] reset during bus read");
    loadRa0(25'h0A_BCDE);
    dmaCmd(1'b0, 3'd1);
    i_dmaReq = 1'b1; i_dmaWe = 1'b0; i_dmaLast = 1'b1;
    applyStimulus();
    i_dmaReq = 1'b0;
    applyStimulus();
    checkOutput("rstMidReq", o_busReq, 1);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("rstMidBusReq", o_busReq, 0);
    checkOutput("rstMidBusA", o_busA, 0);
    checkOutput("rstMidBusy", o_busy, 0);
    checkOutput("rstMidDi", o_dmaDi, 0);
    mRa0 = '0; mWa0 = '0;
    i_dmaLast = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    ackBase = ackClks; endBase = endClks;
    repeat (4) applyStimulus();
    checkOutput("rstNoAck", ackClks - ackBase, 0);
    checkOutput("rstNoEnd", endClks - endBase, 0);
    checkOutput("rstIdle", o_busy, 0);
    dmaCmd(1'b0, 3'd1);
    doReadWord($urandom, 1'b1, 0, 1'b0);

    $display("[TB] CE toggling two-word read");
    ceMode = 1'b1;
    loadRa0(25'(($urandom)));
    dmaCmd(1'b0, 3'd1);
    ackBase = ackClks; endBase = endClks;
    doReadWord($urandom, 1'b0, 1, 1'b0);
    doReadWord($urandom, 1'b1, 0, 1'b0);
    checkOutput("ceAckClks", ackClks - ackBase, 4);
    checkOutput("ceEndClks", endClks - endBase, 2);
    ceMode = 1'b0;

    $display("[TB] randomized transfers");
    for (int t = 0; t < 8; t++) begin
      dir   = 1'($urandom_range(0, 1));
      add   = 3'($urandom_range(0, 7));
      words = $urandom_range(1, 3);
      if (dir) loadWa0(25'($urandom));
      else     loadRa0(25'($urandom));
      dmaCmd(dir, add);
      ackBase = ackClks; endBase = endClks;
      for (int w = 0; w < words; w++) begin
        data  = $urandom;
        delay = $urandom_range(0, 3);
        if (dir) doWriteWord(data, w == words - 1, delay);
        else     doReadWord(data, w == words - 1, delay, 1'b0);
      end
      checkOutput("rndAckCount", ackClks - ackBase, words);
      checkOutput("rndEndCount", endClks - endBase, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/scu_dsp_dma_bridge.md
# scu_dsp_dma_bridge

Bus-side DMA engine for the SCU DSP. Consumes the DSP's DMA request/ack stream, D1-bus address writes (RA0/WA0) and the DMA command word, and executes word transfers on the external SCU bus between DSP data RAM and external memory. It sits directly downstream of the DSP core and upstream of the SCU bus arbiter.

## Interface
- TIMEOUT, 255: CE cycles to wait for BUS_ACK before aborting; counter width is 8 bits.
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- CE  in  1  clock enable; all state advances only when CE=1
- DSO  in  32  DSP D1 bus
- RA0W / WA0W  in  1  load read / write address from DSO[24:0] (word address)
- DMAW  in  1  DSO carries the DMA command: DSO[12]=DIR (1 = DSP→bus), DSO[17:15]=ADD
- DMA_REQ  in  1  one-cycle request for one word
- DMA_ACK  out  1  one-cycle word-accept pulse
- DMA_DI  out  32  read data to the DSP
- DMA_DO  in  32  write data from the DSP
- DMA_WE  in  1  DSP-side direction (must equal latched DIR)
- DMA_RUN  in  1  DSP transfer active (T0)
- DMA_LAST  in  1  current word is the last
- DMA_END  out  1  one-cycle end-of-transfer pulse
- BUS_A  out  25  word address; BUS_DO out 32; BUS_DI in 32; BUS_WE out 1
- BUS_REQ  out  1  held until BUS_ACK; BUS_ACK in 1 (one-cycle)
- BUSY out 1; ERR out 1 (sticky timeout flag)

## Operation
- Registers: RA0, WA0 (25 bits), DIR, ADD, PEND, LAST_L, DIN, TOCNT.
- Step = 0 if ADD=0, else 2^(ADD-1) words. Reads use step 1 if ADD≠0. Addresses wrap modulo 2^25.
- DMAW latches DIR and ADD, clears ERR, and arms the engine. RA0W/WA0W are honoured only in IDLE; when BUSY they are ignored. Same-cycle DMAW+RA0W/WA0W: both take effect.
- DMA_REQ sets PEND (depth 1). A REQ while PEND=1 is dropped. A REQ while unarmed is ignored.
- FSM states: IDLE, RD_BUS, RD_ACK, WR_ACK, WR_BUS, DONE.
  - IDLE: on PEND, enter RD_BUS if DIR=0, WR_ACK if DIR=1. LAST_L←DMA_LAST.
  - RD_BUS: BUS_REQ=1, BUS_WE=0, BUS_A=RA0. On BUS_ACK: DIN←BUS_DI, RA0+=step, go to RD_ACK.
  - RD_ACK: DMA_ACK pulse, clear PEND. Go to DONE if LAST_L, else IDLE.
  - WR_ACK: capture DMA_DO into DIN, DMA_ACK pulse, clear PEND, go to WR_BUS.
  - WR_BUS: BUS_REQ=1, BUS_WE=1, BUS_A=WA0, BUS_DO=DIN. On BUS_ACK: WA0+=step, go to DONE if LAST_L, else IDLE.
  - DONE: DMA_END pulse, disarm, go to IDLE.
- Timeout: TOCNT resets on entering RD_BUS/WR_BUS. If it reaches TIMEOUT without BUS_ACK: ERR←1, drop BUS_REQ, go to DONE.
- DMA_WE≠DIR at request: ERR←1, go to DONE (no bus access).
- DMA_RUN falling while BUSY: finish the current bus access, then IDLE without DMA_END.
- BUSY = state≠IDLE or PEND.

## Timing
- Reset values: all outputs 0, RA0=WA0=0, state IDLE, unarmed.
- Read word: REQ at cycle n → BUS_REQ at n+2 → BUS_ACK at k → DMA_ACK at k+1, DMA_DI valid from k+1 until the next capture.
- Write word: REQ at n → DMA_ACK at n+2 → BUS_REQ at n+3.
- DMA_END follows the last DMA_ACK (read) or the last BUS_ACK (write) by exactly 1 CE cycle.
- BUS_A, BUS_DO and BUS_WE are stable while BUS_REQ=1.
- CE=0 freezes all state; pulse outputs stay held for their CE cycle.

## Structure
- SCUDSP_PKG gets: DspDmaState_t enum, DMA command field positions (DIR bit 12, ADD 17:15), and the AddStep() function.
- Single module, no sub-modules.

## Test plan
- RA0W with DSO=0x0000100, DMAW with DIR=0/ADD=1, 3 REQs (LAST on the 3rd), bus returns 0xA,0xB,0xC → BUS_A reads 0x100,0x101,0x102; DMA_DI 0xA,0xB,0xC with one DMA_ACK each; one DMA_END; final RA0=0x103.
- WA0W=0x1FFFFFF, DIR=1/ADD=3, 2 words 0x11,0x22 → writes to 0x1FFFFFF then 0x0000003 (wrap); DMA_END after the 2nd BUS_ACK.
- BUS_ACK withheld for 255 cycles → ERR=1, BUS_REQ dropped, DMA_END pulse; next DMAW clears ERR.
- Second DMA_REQ while PEND=1 → dropped, only one bus access; RA0W while BUSY → RA0 unchanged.
- RST_N low mid RD_BUS → BUS_REQ=0 immediately, all outputs 0; after release, IDLE with no spurious ACK or END.
- CE toggling 1/0 every cycle during a 2-word read → same results, pulses last one CE cycle.
